bus_arbiter: RTL and testbench

Shares the single external memory bus between the instruction-fetch requester (IF) and the data-access requester (MEM) of the five-stage pipeline. Sequences one bus transaction at a time with a registered strobe/ack handshake and a watchdog timeout. Raises a stall request toward the pipeline controller while any requester is waiting. Honours the controller's flush by draining an in-flight fetch and discarding its result.

---
 rtl/bus_arbiter_pkg.sv | 26 ++
 rtl/bus_arbiter_if.sv | 24 ++
 rtl/bus_watchdog.sv | 27 ++
 rtl/bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared widths, FSM state encoding and bus payload type for the memory-bus arbiter.
package bus_arbiter_pkg;

    localparam int unsigned REG_BUS_W = 32;
    localparam int unsigned SEL_W     = 4;
    localparam int unsigned CNT_W     = 8;

    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_MEM = 2'd2,
        ST_DRAIN    = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                 we;
        logic [SEL_W-1:0]     sel;
        logic [REG_BUS_W-1:0] addr;
        logic [REG_BUS_W-1:0] data;
    } bus_req_t;

    localparam bus_req_t BUS_REQ_IDLE = '0;

endpackage

// File: rtl/bus_arbiter_if.sv
// External memory bus: strobe/ack handshake plus the arbiter's timeout pulse.
interface bus_arbiter_if;
    import bus_arbiter_pkg::*;

    logic                 bus_stb_o;
    logic                 bus_we_o;
    logic [SEL_W-1:0]     bus_sel_o;
    logic [REG_BUS_W-1:0] bus_addr_o;
    logic [REG_BUS_W-1:0] bus_data_o;
    logic [REG_BUS_W-1:0] bus_data_i;
    logic                 bus_ack_i;
    logic                 bus_err_o;

    modport master (
        output bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, bus_err_o,
        input  bus_data_i, bus_ack_i
    );

    modport slave (
        input  bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, bus_err_o,
        output bus_data_i, bus_ack_i
    );

endinterface

// File: rtl/bus_watchdog.sv
// Counts un-acked strobe cycles; expired fires on the cycle the count would reach TIMEOUT.
module bus_watchdog
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (run && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = run && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the shared memory bus between fetch (IF) and data access (MEM), MEM first,
// with flush draining of in-flight fetches and a watchdog timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 if_req_i,
    input  logic [REG_BUS_W-1:0] if_addr_i,
    output logic [REG_BUS_W-1:0] if_data_o,
    output logic                 if_done_o,
    input  logic                 mem_req_i,
    input  logic                 mem_we_i,
    input  logic [SEL_W-1:0]     mem_sel_i,
    input  logic [REG_BUS_W-1:0] mem_addr_i,
    input  logic [REG_BUS_W-1:0] mem_data_i,
    output logic [REG_BUS_W-1:0] mem_data_o,
    output logic                 mem_done_o,
    bus_arbiter_if.master        bus,
    output logic                 stallreq_o
);

    arb_state_e           r_state,    w_state_nxt;
    bus_req_t             r_req,      w_req_nxt;
    logic                 r_stb,      w_stb_nxt;
    logic [REG_BUS_W-1:0] r_if_data,  w_if_data_nxt;
    logic                 r_if_done,  w_if_done_nxt;
    logic [REG_BUS_W-1:0] r_mem_data, w_mem_data_nxt;
    logic                 r_mem_done, w_mem_done_nxt;
    logic                 r_err,      w_err_nxt;
    logic                 w_run;
    logic                 w_clear;
    logic                 w_expired;

    assign w_run   = (r_state != ST_IDLE) && !bus.bus_ack_i;
    assign w_clear = (w_state_nxt != r_state) && (w_state_nxt != ST_IDLE);

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .run     (w_run),
        .expired (w_expired)
    );

    // A requester whose done is pulsing this cycle is already served; don't re-grant it.
    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_stb_nxt      = r_stb;
        w_if_data_nxt  = r_if_data;
        w_if_done_nxt  = 1'b0;
        w_mem_data_nxt = r_mem_data;
        w_mem_done_nxt = 1'b0;
        w_err_nxt      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (mem_req_i && !r_mem_done) begin
                    w_state_nxt    = ST_BUSY_MEM;
                    w_stb_nxt      = 1'b1;
                    w_req_nxt.we   = mem_we_i;
                    w_req_nxt.sel  = mem_sel_i;
                    w_req_nxt.addr = mem_addr_i;
                    w_req_nxt.data = mem_data_i;
                end else if (if_req_i && !r_if_done && !flush) begin
                    w_state_nxt    = ST_BUSY_IF;
                    w_stb_nxt      = 1'b1;
                    w_req_nxt.we   = 1'b0;
                    w_req_nxt.sel  = {SEL_W{1'b1}};
                    w_req_nxt.addr = if_addr_i;
                    w_req_nxt.data = ZERO_WORD;
                end
            end
            ST_BUSY_IF: begin
                if (bus.bus_ack_i) begin
                    w_state_nxt = ST_IDLE;
                    w_stb_nxt   = 1'b0;
                    if (!flush) begin
                        w_if_data_nxt = bus.bus_data_i;
                        w_if_done_nxt = 1'b1;
                    end
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_stb_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    if (!flush) begin
                        w_if_data_nxt = ZERO_WORD;
                        w_if_done_nxt = 1'b1;
                    end
                end else if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_BUSY_MEM: begin
                if (bus.bus_ack_i) begin
                    w_state_nxt    = ST_IDLE;
                    w_stb_nxt      = 1'b0;
                    w_mem_data_nxt = bus.bus_data_i;
                    w_mem_done_nxt = 1'b1;
                end else if (w_expired) begin
                    w_state_nxt    = ST_IDLE;
                    w_stb_nxt      = 1'b0;
                    w_err_nxt      = 1'b1;
                    w_mem_data_nxt = ZERO_WORD;
                    w_mem_done_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (bus.bus_ack_i) begin
                    w_state_nxt = ST_IDLE;
                    w_stb_nxt   = 1'b0;
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_stb_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_stb_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req      <= BUS_REQ_IDLE;
            r_stb      <= 1'b0;
            r_if_data  <= ZERO_WORD;
            r_if_done  <= 1'b0;
            r_mem_data <= ZERO_WORD;
            r_mem_done <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_stb      <= w_stb_nxt;
            r_if_data  <= w_if_data_nxt;
            r_if_done  <= w_if_done_nxt;
            r_mem_data <= w_mem_data_nxt;
            r_mem_done <= w_mem_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.bus_stb_o  = r_stb;
    assign bus.bus_we_o   = r_req.we;
    assign bus.bus_sel_o  = r_req.sel;
    assign bus.bus_addr_o = r_req.addr;
    assign bus.bus_data_o = r_req.data;
    assign bus.bus_err_o  = r_err;

    assign if_data_o  = r_if_data;
    assign if_done_o  = r_if_done;
    assign mem_data_o = r_mem_data;
    assign mem_done_o = r_mem_done;

    assign stallreq_o = (mem_req_i & ~r_mem_done) | (if_req_i & ~r_if_done & ~flush);

endmodule

// File: tb/tb_bus_arbiter.sv
// Cycle-driven bench for bus_arbiter: completion data scoreboarded, handshake timing checked per cycle.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_sel = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;

    logic [31:0] if_data,  to_if_data;
    logic        if_done,  to_if_done;
    logic [31:0] mem_data, to_mem_data;
    logic        mem_done, to_mem_done;
    logic        stall,    to_stall;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_if_q[$];
    logic [31:0] exp_mem_q[$];

    bus_arbiter_if bus_m();
    bus_arbiter_if bus_t();

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_done_o(if_done),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
        .mem_data_i(mem_wdata), .mem_data_o(mem_data), .mem_done_o(mem_done),
        .bus(bus_m.master), .stallreq_o(stall)
    );

    // Second instance with a short watchdog and a slave that never acks.
    bus_arbiter #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(to_if_data), .if_done_o(to_if_done),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
        .mem_data_i(mem_wdata), .mem_data_o(to_mem_data), .mem_done_o(to_mem_done),
        .bus(bus_t.master), .stallreq_o(to_stall)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Scoreboard: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_done) begin
                if (exp_if_q.size() == 0) check("if_done_spurious", {31'b0, if_done}, 32'd0);
                else check("if_data", if_data, exp_if_q.pop_front());
            end
            if (mem_done) begin
                if (exp_mem_q.size() == 0) check("mem_done_spurious", {31'b0, mem_done}, 32'd0);
                else check("mem_data", mem_data, exp_mem_q.pop_front());
            end
            if (bus_m.bus_err_o) check("err_spurious", {31'b0, bus_m.bus_err_o}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x00000001 expected 0x00000000");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        bus_m.bus_ack_i  = 1'b0;
        bus_m.bus_data_i = '0;
        bus_t.bus_ack_i  = 1'b0;
        bus_t.bus_data_i = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        sample();
        check("rst_stb",   {31'b0, bus_m.bus_stb_o}, 32'd0);
        check("rst_addr",  bus_m.bus_addr_o, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);

        // Lone fetch, zero-wait slave
        next_cycle(); if_req = 1'b1; if_addr = 32'h0000_0100;
        sample(); check("t1_c0_stb", {31'b0, bus_m.bus_stb_o}, 32'd0);
        check("t1_c0_stall", {31'b0, stall}, 32'd1);
        next_cycle(); bus_m.bus_ack_i = 1'b1; bus_m.bus_data_i = 32'h3C01_0001;
        exp_if_q.push_back(32'h3C01_0001);
        sample(); check("t1_c1_stb", {31'b0, bus_m.bus_stb_o}, 32'd1);
        check("t1_c1_addr", bus_m.bus_addr_o, 32'h0000_0100);
        check("t1_c1_we", {31'b0, bus_m.bus_we_o}, 32'd0);
        check("t1_c1_stall", {31'b0, stall}, 32'd1);
        next_cycle(); bus_m.bus_ack_i = 1'b0;
        sample(); check("t1_c2_stb", {31'b0, bus_m.bus_stb_o}, 32'd0);
        check("t1_c2_done", {31'b0, if_done}, 32'd1);
        check("t1_c2_stall", {31'b0, stall}, 32'd0);
        next_cycle(); if_req = 1'b0;
        sample(); check("t1_c3_done", {31'b0, if_done}, 32'd0);

        // Simultaneous MEM write and IF read: MEM first
        next_cycle();
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b1111;
        mem_addr = 32'h0000_0200; mem_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h0000_0104;
        next_cycle(); bus_m.bus_ack_i = 1'b1; bus_m.bus_data_i = 32'h1111_1111;
        exp_mem_q.push_back(32'h1111_1111);
        sample(); check("t2_c1_stb", {31'b0, bus_m.bus_stb_o}, 32'd1);
        check("t2_c1_we", {31'b0, bus_m.bus_we_o}, 32'd1);
        check("t2_c1_addr", bus_m.bus_addr_o, 32'h0000_0200);
        check("t2_c1_wdata", bus_m.bus_data_o, 32'hDEAD_BEEF);
        check("t2_c1_sel", {28'b0, bus_m.bus_sel_o}, 32'hF);
        next_cycle(); bus_m.bus_ack_i = 1'b0;
        sample(); check("t2_c2_mem_done", {31'b0, mem_done}, 32'd1);
        check("t2_c2_stb", {31'b0, bus_m.bus_stb_o}, 32'd0);
        next_cycle(); mem_req = 1'b0; mem_we = 1'b0;
        bus_m.bus_ack_i = 1'b1; bus_m.bus_data_i = 32'hA5A5_A5A5;
        exp_if_q.push_back(32'hA5A5_A5A5);
        sample(); check("t2_c3_stb", {31'b0, bus_m.bus_stb_o}, 32'd1);
        check("t2_c3_addr", bus_m.bus_addr_o, 32'h0000_0104);
        check("t2_c3_we", {31'b0, bus_m.bus_we_o}, 32'd0);
        next_cycle(); bus_m.bus_ack_i = 1'b0;
        sample(); check("t2_c4_if_done", {31'b0, if_done}, 32'd1);
        next_cycle(); if_req = 1'b0;

        // Flush during a 4-wait-state fetch drains without a done pulse
        next_cycle(); if_req = 1'b1; if_addr = 32'h0000_0108;
        next_cycle();
        sample(); check("t3_c1_stb", {31'b0, bus_m.bus_stb_o}, 32'd1);
        next_cycle(); flush = 1'b1;
        sample(); check("t3_c2_stall", {31'b0, stall}, 32'd0);
        next_cycle(); flush = 1'b0; if_req = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            if (c == 5) begin bus_m.bus_ack_i = 1'b1; bus_m.bus_data_i = 32'hBAD0_BAD0; end
            sample(); check($sformatf("t3_c%0d_stb", c), {31'b0, bus_m.bus_stb_o}, 32'd1);
            check($sformatf("t3_c%0d_done", c), {31'b0, if_done}, 32'd0);
            next_cycle();
        end
        bus_m.bus_ack_i = 1'b0; if_req = 1'b1; if_addr = 32'h0000_010C;
        sample(); check("t3_c6_stb", {31'b0, bus_m.bus_stb_o}, 32'd0);
        check("t3_c6_done", {31'b0, if_done}, 32'd0);
        next_cycle(); bus_m.bus_ack_i = 1'b1; bus_m.bus_data_i = 32'h1234_5678;
        exp_if_q.push_back(32'h1234_5678);
        sample(); check("t3_c7_stb", {31'b0, bus_m.bus_stb_o}, 32'd1);
        check("t3_c7_addr", bus_m.bus_addr_o, 32'h0000_010C);
        next_cycle(); bus_m.bus_ack_i = 1'b0;
        sample(); check("t3_c8_done", {31'b0, if_done}, 32'd1);
        next_cycle(); if_req = 1'b0;

        // Flush during a MEM read is ignored
        next_cycle(); mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'b0011; mem_addr = 32'h0000_0300;
        next_cycle();
        sample(); check("t4_c1_sel", {28'b0, bus_m.bus_sel_o}, 32'h3);
        next_cycle(); flush = 1'b1;
        next_cycle(); flush = 1'b0; bus_m.bus_ack_i = 1'b1; bus_m.bus_data_i = 32'hCAFE_F00D;
        exp_mem_q.push_back(32'hCAFE_F00D);
        sample(); check("t4_c3_stb", {31'b0, bus_m.bus_stb_o}, 32'd1);
        next_cycle(); bus_m.bus_ack_i = 1'b0;
        sample(); check("t4_c4_mem_done", {31'b0, mem_done}, 32'd1);
        check("t4_c4_stb", {31'b0, bus_m.bus_stb_o}, 32'd0);
        next_cycle(); mem_req = 1'b0;

        // Reset mid-transaction aborts regardless of ack
        next_cycle(); if_req = 1'b1; if_addr = 32'h0000_0400;
        next_cycle();
        sample(); check("t6_c1_stb", {31'b0, bus_m.bus_stb_o}, 32'd1);
        next_cycle(); rst = 1'b1; bus_m.bus_ack_i = 1'b1; bus_m.bus_data_i = 32'hFFFF_FFFF;
        next_cycle(); rst = 1'b0; if_req = 1'b0;
        sample(); check("t6_stb",      {31'b0, bus_m.bus_stb_o}, 32'd0);
        check("t6_addr",     bus_m.bus_addr_o, 32'd0);
        check("t6_we_sel",   {27'b0, bus_m.bus_we_o, bus_m.bus_sel_o}, 32'd0);
        check("t6_if_data",  if_data, 32'd0);
        check("t6_mem_data", mem_data, 32'd0);
        check("t6_dones",    {30'b0, if_done, mem_done}, 32'd0);
        next_cycle(); bus_m.bus_ack_i = 1'b0;
        sample(); check("t6_post_done", {31'b0, if_done}, 32'd0);
        check("t6_post_stb", {31'b0, bus_m.bus_stb_o}, 32'd0);

        // Watchdog expiry on the TIMEOUT=4 instance
        next_cycle(); if_req = 1'b1; if_addr = 32'h0000_0500;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            sample(); check($sformatf("t5_c%0d_stb", c), {31'b0, bus_t.bus_stb_o}, 32'd1);
            check($sformatf("t5_c%0d_err", c), {31'b0, bus_t.bus_err_o}, 32'd0);
            check($sformatf("t5_c%0d_stall", c), {31'b0, to_stall}, 32'd1);
        end
        next_cycle();
        sample(); check("t5_c5_stb", {31'b0, bus_t.bus_stb_o}, 32'd0);
        check("t5_c5_err", {31'b0, bus_t.bus_err_o}, 32'd1);
        check("t5_c5_done", {31'b0, to_if_done}, 32'd1);
        check("t5_c5_data", to_if_data, 32'd0);
        check("t5_c5_mem_done", {31'b0, to_mem_done}, 32'd0);
        next_cycle(); if_req = 1'b0;
        sample(); check("t5_c6_err", {31'b0, bus_t.bus_err_o}, 32'd0);
        check("t5_c6_done", {31'b0, to_if_done}, 32'd0);
        check("t5_mem_data", to_mem_data, 32'd0);

        check("if_queue_empty",  32'(exp_if_q.size()), 32'd0);
        check("mem_queue_empty", 32'(exp_mem_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
